// File: rtl/cap_pkg.sv
// Shared types and width helpers for the CAM tag (responder) array.
package cap_pkg;

  typedef enum logic [2:0] {
    OP_NOP     = 3'd0,
    OP_LOAD    = 3'd1,
    OP_AND     = 3'd2,
    OP_OR      = 3'd3,
    OP_CLEAR   = 3'd4,
    OP_SET_ALL = 3'd5,
    OP_SEL_1ST = 3'd6,
    OP_ITERATE = 3'd7
  } op_e;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_ITER = 1'b1
  } state_e;

  function automatic int idx_w(input int words);
    return $clog2(words);
  endfunction

  function automatic int cnt_w(input int words);
    return $clog2(words + 1);
  endfunction

endpackage

// File: rtl/cap_priority_enc.sv
// Lowest-set-bit finder: index, isolated one-hot bit, and any-set flag.
module cap_priority_enc #(
  parameter int W  = 8,
  parameter int IW = 3
) (
  input  logic [W-1:0]  vec,
  output logic [IW-1:0] idx,
  output logic [W-1:0]  onehot,
  output logic          any
);

  assign onehot = vec & (~vec + W'(1));
  assign any    = |vec;

  // Scan downward so the lowest set bit wins the final assignment.
  always_comb begin
    idx = '0;
    for (int i = W - 1; i >= 0; i--) begin
      if (vec[i]) idx = IW'(i);
    end
  end

endmodule

// File: rtl/cap_tag_array.sv
// Responder tag vector for a CAM with set ops and responder iteration.
// Optional tag_count output enabled by CAP_TAG_COUNT_EN.
module cap_tag_array
  import cap_pkg::*;
#(
  parameter int WORDS = 100,
  localparam int IDX_W = idx_w(WORDS)
`ifdef CAP_TAG_COUNT_EN
  , localparam int CNT_W = cnt_w(WORDS)
`endif
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [WORDS-1:0] match_lines,
  input  logic             op_valid,
  input  logic [2:0]       op_code,
  output logic             op_ready,
  output logic [WORDS-1:0] tags,
  output logic             some,
  output logic             none,
  output logic             resp_valid,
  output logic [IDX_W-1:0] resp_idx,
  output logic             resp_last,
  input  logic             resp_ready
`ifdef CAP_TAG_COUNT_EN
  , output logic [CNT_W-1:0] tag_count
`endif
);

  logic [WORDS-1:0] tags_q, tags_d;
  logic [WORDS-1:0] work_q, work_d;
  state_e           state_q, state_d;

  logic [IDX_W-1:0] tg_idx;
  logic [WORDS-1:0] tg_oh;
  logic             tg_any;
  logic [WORDS-1:0] wk_oh;
  logic             wk_any;
  logic             unused_pe;

  cap_priority_enc #(.W(WORDS), .IW(IDX_W)) u_pe_tags (
    .vec    (tags_q),
    .idx    (tg_idx),
    .onehot (tg_oh),
    .any    (tg_any)
  );

  cap_priority_enc #(.W(WORDS), .IW(IDX_W)) u_pe_work (
    .vec    (work_q),
    .idx    (resp_idx),
    .onehot (wk_oh),
    .any    (wk_any)
  );

  assign unused_pe  = ^{tg_idx, wk_any};

  assign tags       = tags_q;
  assign some       = tg_any;
  assign none       = ~tg_any;
  assign op_ready   = (state_q == ST_IDLE);
  assign resp_valid = (state_q == ST_ITER);
  assign resp_last  = resp_valid && ((work_q & (work_q - WORDS'(1))) == '0);

  always_comb begin
    tags_d  = tags_q;
    work_d  = work_q;
    state_d = state_q;
    if (state_q == ST_ITER) begin
      if (resp_ready) begin
        work_d = work_q & ~wk_oh;
        if (resp_last) state_d = ST_IDLE;
      end
    end else if (op_valid) begin
      case (op_e'(op_code))
        OP_LOAD:    tags_d = match_lines;
        OP_AND:     tags_d = tags_q & match_lines;
        OP_OR:      tags_d = tags_q | match_lines;
        OP_CLEAR:   tags_d = '0;
        OP_SET_ALL: tags_d = '1;
        OP_SEL_1ST: tags_d = tg_oh;
        OP_ITERATE: begin
          if (tg_any) begin
            work_d  = tags_q;
            state_d = ST_ITER;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      tags_q  <= '0;
      work_q  <= '0;
      state_q <= ST_IDLE;
    end else begin
      tags_q  <= tags_d;
      work_q  <= work_d;
      state_q <= state_d;
    end
  end

`ifdef CAP_TAG_COUNT_EN
  always_comb begin
    tag_count = '0;
    for (int i = 0; i < WORDS; i++) begin
      tag_count = tag_count + CNT_W'(tags_q[i]);
    end
  end
`endif

endmodule

// File: tb/tb_cap_tag_array.sv
// Directed and random checks of cap_tag_array (WORDS=8) against a
// queue-based reference model.
module tb_cap_tag_array;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic [7:0] match_lines;
  logic       op_valid;
  logic [2:0] op_code;
  logic       op_ready;
  logic [7:0] tags;
  logic       some;
  logic       none;
  logic       resp_valid;
  logic [2:0] resp_idx;
  logic       resp_last;
  logic       resp_ready;
`ifdef CAP_TAG_COUNT_EN
  logic [3:0] tag_count;
`endif

  int tests = 0;
  int fails = 0;

  logic [7:0] m_tags;
  bit         m_iter;
  int         q[$];

  cap_tag_array #(.WORDS(8)) dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .match_lines (match_lines),
    .op_valid    (op_valid),
    .op_code     (op_code),
    .op_ready    (op_ready),
    .tags        (tags),
    .some        (some),
    .none        (none),
    .resp_valid  (resp_valid),
    .resp_idx    (resp_idx),
    .resp_last   (resp_last),
    .resp_ready  (resp_ready)
`ifdef CAP_TAG_COUNT_EN
    , .tag_count (tag_count)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    tests++;
    assert (got === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string where);
    check({where, " tags"}, 32'(tags), 32'(m_tags));
    check({where, " some"}, 32'(some), 32'(m_tags != 8'h00));
    check({where, " none"}, 32'(none), 32'(m_tags == 8'h00));
    check({where, " op_ready"}, 32'(op_ready), 32'(!m_iter));
    check({where, " resp_valid"}, 32'(resp_valid), 32'(m_iter));
    if (m_iter) begin
      check({where, " resp_idx"}, 32'(resp_idx), 32'(q[0]));
      check({where, " resp_last"}, 32'(resp_last), 32'(q.size() == 1));
    end
`ifdef CAP_TAG_COUNT_EN
    check({where, " tag_count"}, 32'(tag_count), 32'($countones(m_tags)));
`endif
  endtask

  task automatic model_reset();
    m_tags = 8'h00;
    m_iter = 1'b0;
    q.delete();
  endtask

  task automatic model_edge(input bit v, input logic [2:0] c,
                            input logic [7:0] m, input bit rr);
    int d;
    int first;
    if (m_iter) begin
      if (rr) begin
        d = q.pop_front();
        if (q.size() == 0) m_iter = 1'b0;
      end
    end else if (v) begin
      case (c)
        3'd1: m_tags = m;
        3'd2: m_tags = m_tags & m;
        3'd3: m_tags = m_tags | m;
        3'd4: m_tags = 8'h00;
        3'd5: m_tags = 8'hFF;
        3'd6: begin
          first = -1;
          for (int i = 7; i >= 0; i--) if (m_tags[i]) first = i;
          m_tags = (first < 0) ? 8'h00 : (8'h01 << first);
        end
        3'd7: begin
          if (m_tags != 8'h00) begin
            q.delete();
            for (int i = 0; i < 8; i++) if (m_tags[i]) q.push_back(i);
            m_iter = 1'b1;
          end
        end
        default: ;
      endcase
    end
  endtask

  task automatic step(input string where, input bit v, input logic [2:0] c,
                      input logic [7:0] m, input bit rr);
    op_valid    = v;
    op_code     = c;
    match_lines = m;
    resp_ready  = rr;
    @(posedge CLK);
    model_edge(v, c, m, rr);
    #1;
    check_all(where);
  endtask

  initial begin
    bit         v;
    logic [2:0] c;
    RST_N       = 1'b0;
    op_valid    = 1'b0;
    op_code     = 3'd0;
    match_lines = 8'h00;
    resp_ready  = 1'b0;
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    check_all("reset");
    RST_N = 1'b1;

    step("load", 1, 3'd1, 8'hA4, 0);
    check("load tags A4", 32'(tags), 32'h0000_00A4);
    step("and", 1, 3'd2, 8'h0F, 0);
    check("and tags 04", 32'(tags), 32'h0000_0004);
    step("or", 1, 3'd3, 8'h30, 0);
    check("or tags 34", 32'(tags), 32'h0000_0034);
    step("sel1", 1, 3'd6, 8'h00, 0);
    check("sel1 tags 04", 32'(tags), 32'h0000_0004);

    step("ld91", 1, 3'd1, 8'h91, 1);
    step("it91", 1, 3'd7, 8'h00, 1);
    check("it91 idx0", 32'(resp_idx), 32'd0);
    step("it91 a", 0, 3'd0, 8'h00, 1);
    check("it91 idx4", 32'(resp_idx), 32'd4);
    step("it91 b", 0, 3'd0, 8'h00, 1);
    check("it91 idx7 last", 32'({resp_idx, resp_last}), 32'({3'd7, 1'b1}));
    step("it91 c", 0, 3'd0, 8'h00, 1);
    check("it91 done tags", 32'(tags), 32'h0000_0091);

    step("ld06", 1, 3'd1, 8'h06, 0);
    step("it06", 1, 3'd7, 8'h00, 0);
    for (int i = 0; i < 3; i++) step("stall", 1, 3'd1, 8'h55, 0);
    check("stall idx1", 32'(resp_idx), 32'd1);
    step("rel1", 0, 3'd0, 8'h00, 1);
    check("rel idx2", 32'(resp_idx), 32'd2);
    step("rel2", 0, 3'd0, 8'h00, 1);

    step("clr", 1, 3'd4, 8'h00, 0);
    step("itz", 1, 3'd7, 8'h00, 1);
    step("itz2", 0, 3'd0, 8'h00, 1);
    check("sel1 zero", 32'(tags), 32'd0);
    step("sel1z", 1, 3'd6, 8'h00, 0);

    step("setall", 1, 3'd5, 8'h00, 0);
    step("itff", 1, 3'd7, 8'h00, 0);
    step("itff a", 0, 3'd0, 8'h00, 1);
    #2 RST_N = 1'b0;
    model_reset();
    #1;
    check_all("async rst");
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
    check_all("after rst");

    for (int n = 0; n < 400; n++) begin
      v = ($urandom_range(0, 3) != 0);
      c = ($urandom_range(0, 4) == 0) ? 3'd7 : 3'($urandom_range(0, 7));
      step("rand", v, c, 8'($urandom), bit'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
